// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives local-store reads from a wrapping PC and delivers
// instructions to decode through a stall-tolerant output register with a 1-entry skid buffer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          LS_ADDR_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [0:31] branch_target,
  input  logic        halt,
  input  logic        stall,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic [0:31] imem_rdata,
  output logic [0:31] instr,
  output logic [0:31] instr_pc,
  output logic        instr_valid,
  output logic        flush,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Keeps word alignment and the local-store address range in one mask.
  localparam logic [63:0] LS_SPAN   = 64'd1 << LS_ADDR_BITS;
  localparam logic [0:31] ADDR_MASK = (LS_SPAN[31:0] - 32'd1) & 32'hFFFF_FFFC;

  function automatic logic [0:31] norm_pc(input logic [0:31] a);
    return a & ADDR_MASK;
  endfunction

  logic [1:0]  state_q,       state_d;
  logic [0:31] pc_q,          pc_d;
  logic        rsp_valid_q,   rsp_valid_d;
  logic [0:31] rsp_pc_q,      rsp_pc_d;
  logic        skid_valid_q,  skid_valid_d;
  logic [0:31] skid_instr_q,  skid_instr_d;
  logic [0:31] skid_pc_q,     skid_pc_d;
  logic [0:31] instr_q,       instr_d;
  logic [0:31] instr_pc_q,    instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        flush_q,       flush_d;

  logic        req;
  logic        out_accept;
  logic        take_rsp;

  // Handshake: decode consumes instr when instr_valid=1 and stall=0; the output
  // register refills whenever it is empty or being consumed. A request is only
  // issued when its response is guaranteed a home (output register or skid).
  assign req        = (state_q == ST_FETCH) && !stall && !skid_valid_q;
  assign out_accept = !stall || !instr_valid_q;
  assign take_rsp   = out_accept && !skid_valid_q && rsp_valid_q;

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign flush       = flush_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_pc_d      = rsp_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    flush_d       = 1'b0;

    if (branch_taken) begin
      state_d       = ST_FETCH;
      pc_d          = norm_pc(branch_target);
      rsp_valid_d   = 1'b0;
      skid_valid_d  = 1'b0;
      instr_valid_d = 1'b0;
      flush_d       = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT:   state_d = ST_FETCH;
        ST_FETCH:  if (halt) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_BOOT;
      endcase

      if (req) begin
        pc_d        = norm_pc(pc_q + 32'd4);
        rsp_valid_d = 1'b1;
        rsp_pc_d    = pc_q;
      end else begin
        rsp_valid_d = 1'b0;
      end

      // The skid entry is older than the current response, so it goes first.
      if (out_accept) begin
        if (skid_valid_q) begin
          instr_d       = skid_instr_q;
          instr_pc_d    = skid_pc_q;
          instr_valid_d = 1'b1;
        end else if (rsp_valid_q) begin
          instr_d       = imem_rdata;
          instr_pc_d    = rsp_pc_q;
          instr_valid_d = 1'b1;
        end else begin
          instr_valid_d = 1'b0;
        end
      end

      if (rsp_valid_q && !take_rsp) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d    = rsp_pc_q;
      end else if (out_accept && skid_valid_q) begin
        skid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= norm_pc(RESET_PC);
      rsp_valid_q   <= 1'b0;
      rsp_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_pc_q      <= rsp_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      flush_q       <= flush_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns word = address, one cycle after each request.
module tb_instr_fetch;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic        clk;
  logic        reset;
  logic        branch_taken;
  logic [0:31] branch_target;
  logic        halt;
  logic        stall;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic [0:31] imem_rdata;
  logic [0:31] instr;
  logic [0:31] instr_pc;
  logic        instr_valid;
  logic        flush;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .LS_ADDR_BITS(18)) dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .flush         (flush),
    .dbg_state     (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    step();
    step();
    chk("rst_req",   imem_req,    0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr,       0);
    chk("rst_pc",    instr_pc,    0);
    chk("rst_flush", flush,       0);
    chk("rst_state", dbg_state,   ST_BOOT);

    // cycle 1: BOOT
    reset = 1'b0;
    #1;
    chk("boot_req",   imem_req,  0);
    chk("boot_state", dbg_state, ST_BOOT);
    step(); // cycle 2
    chk("first_req",   imem_req,  1);
    chk("first_addr",  imem_addr, 32'h0);
    chk("fetch_state", dbg_state, ST_FETCH);
    step(); // cycle 3
    chk("lat_valid0", instr_valid, 0);
    chk("addr_c3",    imem_addr,   32'h4);
    step(); // cycle 4
    chk("s0_valid", instr_valid, 1);
    chk("s0_instr", instr,       32'h0);
    chk("s0_pc",    instr_pc,    32'h0);
    step(); // cycle 5
    chk("s1_pc",    instr_pc, 32'h4);
    chk("s1_instr", instr,    32'h4);
    step(); // cycle 6
    chk("s2_pc", instr_pc, 32'h8);
    stall = 1'b1;
    step(); // cycle 7
    chk("stall_hold_pc", instr_pc,    32'h8);
    chk("stall_valid",   instr_valid, 1);
    chk("stall_noreq",   imem_req,    0);
    step(); // cycle 8
    chk("stall_hold2", instr_pc, 32'h8);
    step(); // cycle 9
    chk("stall_hold3", instr_pc, 32'h8);
    stall = 1'b0;
    step(); // cycle 10
    chk("resume_pc",    instr_pc, 32'hC);
    chk("resume_instr", instr,    32'hC);
    step(); // cycle 11
    chk("resume_bubble", instr_valid, 0);
    step(); // cycle 12
    chk("resume_next", instr_pc, 32'h10);
    step(); // cycle 13
    chk("resume_next2", instr_pc, 32'h14);

    branch_taken = 1'b1; branch_target = 32'h0003_FFF8;
    step(); // cycle 14
    branch_taken = 1'b0;
    chk("br1_flush", flush,       1);
    chk("br1_valid", instr_valid, 0);
    chk("br1_addr",  imem_addr,   32'h3FFF8);
    step(); // cycle 15
    chk("br1_flush_off", flush,       0);
    chk("br1_valid2",    instr_valid, 0);
    step(); // cycle 16
    chk("wrap_pc0",   instr_pc,  32'h3FFF8);
    chk("wrap_addr",  imem_addr, 32'h0);
    step(); // cycle 17
    chk("wrap_pc1", instr_pc, 32'h3FFFC);
    step(); // cycle 18
    chk("wrap_pc2",    instr_pc, 32'h0);
    chk("wrap_valid2", instr_valid, 1);

    stall = 1'b1;
    step(); // cycle 19: skid holds 0x4
    chk("skid_hold", instr_pc, 32'h0);
    chk("skid_noreq", imem_req, 0);
    branch_taken = 1'b1; branch_target = 32'h0000_1237;
    step(); // cycle 20
    branch_taken = 1'b0; stall = 1'b0;
    chk("br2_flush", flush,       1);
    chk("br2_valid", instr_valid, 0);
    chk("br2_addr",  imem_addr,   32'h1234);
    step(); // cycle 21
    chk("br2_flush_off", flush,       0);
    chk("br2_valid2",    instr_valid, 0);
    step(); // cycle 22
    chk("br2_pc",    instr_pc,    32'h1234);
    chk("br2_instr", instr,       32'h1234);
    chk("br2_vld",   instr_valid, 1);
    step(); // cycle 23
    chk("br2_next", instr_pc, 32'h1238);

    branch_taken = 1'b1; branch_target = 32'h0000_0038;
    step(); // cycle 24
    branch_taken = 1'b0;
    chk("br3_addr", imem_addr, 32'h38);
    step(); // cycle 25
    step(); // cycle 26
    chk("h_pc38",   instr_pc,  32'h38);
    chk("h_addr40", imem_addr, 32'h40);
    halt = 1'b1;
    step(); // cycle 27
    halt = 1'b0;
    chk("h_state", dbg_state, ST_HALTED);
    chk("h_noreq", imem_req,  0);
    chk("h_drain1", instr_pc, 32'h3C);
    step(); // cycle 28
    chk("h_drain2", instr_pc,    32'h40);
    chk("h_drain2v", instr_valid, 1);
    step(); // cycle 29
    chk("h_empty", instr_valid, 0);
    chk("h_noreq2", imem_req,   0);
    step(); // cycle 30
    chk("h_noreq3", imem_req, 0);
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    step(); // cycle 31
    branch_taken = 1'b0;
    chk("h_br_flush", flush,     1);
    chk("h_br_req",   imem_req,  1);
    chk("h_br_addr",  imem_addr, 32'h100);
    step(); // cycle 32
    step(); // cycle 33
    chk("h_resume", instr_pc, 32'h100);

    stall = 1'b1;
    step(); // cycle 34
    chk("r_hold", instr_valid, 1);
    reset = 1'b1;
    #1;
    chk("r_valid", instr_valid, 0);
    chk("r_flush", flush,       0);
    chk("r_req",   imem_req,    0);
    chk("r_pc",    instr_pc,    0);
    step(); // cycle 35
    reset = 1'b0; stall = 1'b0;
    #1;
    chk("r_boot",   dbg_state, ST_BOOT);
    chk("r_boot_req", imem_req, 0);
    step(); // cycle 36
    chk("r_req1",  imem_req,  1);
    chk("r_addr1", imem_addr, 32'h0);
    step(); // cycle 37
    step(); // cycle 38
    chk("r_first_pc", instr_pc,    32'h0);
    chk("r_first_v",  instr_valid, 1);

    halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
    step(); // cycle 39
    halt = 1'b0; branch_taken = 1'b0;
    chk("prio_state", dbg_state, ST_FETCH);
    chk("prio_flush", flush,     1);
    chk("prio_addr",  imem_addr, 32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded by reset.
REQ-002 Parameter LS_ADDR_BITS, default 18: local-store address width; PC wraps modulo 2^LS_ADDR_BITS.
REQ-003 Port clk  in  1: single clock; all state updates on posedge clk.
REQ-004 Port reset  in  1: reset is asynchronous and active-high.
REQ-005 Port branch_taken  in  1: redirect request from the Branch stage.
REQ-006 Port branch_target  in  [0:31]: redirect address from the Branch stage, e.g. bi target ra[0:31] & 32'hFFFFFFFC.
REQ-007 Port halt  in  1: stop request from decode.
REQ-008 Port stall  in  1: decode cannot accept an instruction this cycle.
REQ-009 Port imem_req  out  1: local-store read request.
REQ-010 Port imem_addr  out  [0:31]: local-store read address.
REQ-011 Port imem_rdata  in  [0:31]: read data, valid exactly 1 cycle after the edge that sampled imem_req=1.
REQ-012 Port instr  out  [0:31]: fetched instruction to decode.
REQ-013 Port instr_pc  out  [0:31]: address of instr.
REQ-014 Port instr_valid  out  1: instr/instr_pc hold a valid instruction.
REQ-015 Port flush  out  1: one-cycle pulse telling downstream stages to squash in-flight instructions.

Function
REQ-016 Registered state: PC, FSM state, response tag (rsp_valid, rsp_pc), 1-entry skid buffer (skid_valid, skid_instr, skid_pc), output register (instr, instr_pc, instr_valid), flush.
REQ-017 FSM states: BOOT, FETCH, HALTED.
REQ-018 Transitions: BOOT->FETCH unconditionally after 1 cycle; FETCH->HALTED when halt=1 and branch_taken=0; HALTED->FETCH only on branch_taken=1; any state->FETCH on branch_taken=1.
REQ-019 imem_addr = PC combinationally; imem_req = (state==FETCH) && !stall && !skid_valid.
REQ-020 PC normalization on every load: bits [30:31] forced 0; bits [0:31-LS_ADDR_BITS] forced 0.
REQ-021 Edge with imem_req=1: rsp_valid<=1, rsp_pc<=PC, PC<=(PC+4) normalized; 0x3FFFC with LS_ADDR_BITS=18 wraps to 0x00000.
REQ-022 Edge with imem_req=0: rsp_valid<=0, PC held.
REQ-023 Output register accepts when stall=0 or instr_valid=0; otherwise it holds its value.
REQ-024 When the output register accepts, its source priority is: skid entry first, else the current response (imem_rdata, rsp_pc) when rsp_valid=1, else instr_valid<=0.
REQ-025 A current response not taken by the output register is written into the skid buffer; a skid entry taken by the output register is cleared unless refilled in the same edge.
REQ-026 Instruction order at instr is strictly the fetch-address order; no instruction is duplicated or lost while stalled.
REQ-027 Steady-state latency: imem_req sampled at edge N -> instr_valid=1 with that instruction after edge N+1.
REQ-028 branch_taken=1 at an edge: PC<=branch_target normalized; rsp_valid, skid_valid and instr_valid <=0; flush<=1 for exactly that next cycle; state<=FETCH.
REQ-029 Redirect latency: branch_taken sampled at edge N -> target instruction valid at instr after edge N+2.
REQ-030 branch_taken has priority over halt, stall and all in-flight data in the same cycle.
REQ-031 halt=1 in FETCH: no new requests from the next cycle; an in-flight response and the skid entry still drain to instr.
REQ-032 flush=0 in every cycle not following a branch_taken edge.

Reset
REQ-033 While reset=1: PC=RESET_PC normalized, state=BOOT, rsp_valid=0, skid_valid=0, instr_valid=0, instr=0, instr_pc=0, flush=0, and imem_req=0.
REQ-034 Reset asserted mid-operation discards all in-flight and buffered instructions immediately; the first request after release is at RESET_PC, one cycle after release (BOOT).

Verification
REQ-035 Reset release, memory returns word = address, no stall -> imem_req at 0x0 in cycle 2; instr_valid with instr=0x0, 0x4, 0x8 on consecutive cycles.
REQ-036 stall=1 for 3 cycles while streaming -> instr held; no instruction lost or duplicated; sequence resumes in order after stall=0.
REQ-037 branch_taken=1 with target 0x00001237 while stall=1 and skid full -> flush=1 one cycle; instr_valid=0 for 2 cycles; then instr_pc=0x00001234.
REQ-038 PC=0x3FFF8, free-running -> instr_pc sequence 0x3FFF8, 0x3FFFC, 0x00000.
REQ-039 halt=1 at pc 0x40 -> imem_req=0 thereafter and the already-fetched instructions drain; branch_taken to 0x100 -> fetch resumes at 0x100.
REQ-040 reset asserted for 1 cycle mid-stream with stall=1 -> instr_valid=0 and flush=0 immediately; fetch restarts at RESET_PC after BOOT.
